// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the two-master data bus arbiter: FSM encoding,
// master identifiers and default parameter values.
package dbus_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_WAIT   = 15;
  localparam int DEF_STARVE_LIM = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/dbus_arb_pick.sv
// Combinational winner select: the CPU has fixed priority unless the DMA
// master has been starved long enough, in which case the DMA master wins.
module dbus_arb_pick
  import dbus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic starve_hit,
  output logic any_req,
  output logic winner
);

  // Fixed priority with starvation override
  always_comb begin
    any_req = req0 | req1;
    winner  = M_CPU;
    if (req1 && (starve_hit || !req0)) begin
      winner = M_DMA;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter serialising CPU (m0) and DMA/debug (m1) transfers onto a
// single ready-handshaked slave bus, with lock, starvation guard and a
// wait-state timeout that completes the transfer with an error.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_WAIT   = DEF_MAX_WAIT,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [3:0]        s_we,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready,
  output logic              owner,
  output logic              busy
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic pick_any;
  logic pick_win;
  logic arb;
  logic own_req;
  logic own_lock;
  logic in_xfer;
  logic in_resp;

  dbus_arb_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .starve_hit (starve_cnt_q == STARVE_MAX),
    .any_req    (pick_any),
    .winner     (pick_win)
  );

  // Next-state, counter and response-register computation
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    arb          = 1'b0;
    own_req      = (owner_q == M_DMA) ? m1_req  : m0_req;
    own_lock     = (owner_q == M_DMA) ? m1_lock : m0_lock;

    case (state_q)
      IDLE: begin
        if (pick_any) arb = 1'b1;
      end
      XFER: begin
        // s_ready wins over a timeout reached in the same cycle
        if (s_ready) begin
          if (owner_q == M_DMA) m1_rdata_d = s_rdata;
          else                  m0_rdata_d = s_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wait_cnt_q == WAIT_MAX) begin
          if (owner_q == M_DMA) m1_rdata_d = '0;
          else                  m0_rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        // A locked owner re-requesting keeps the bus without arbitration
        if (own_lock && own_req) begin
          state_d    = XFER;
          wait_cnt_d = '0;
        end else if (pick_any) begin
          arb = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb) begin
      state_d    = XFER;
      owner_d    = pick_win;
      wait_cnt_d = '0;
      if (pick_win == M_CPU && m1_req) begin
        starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                    : starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  // State and response registers; reset abandons any transfer in flight
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= M_CPU;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Output decode from registered state; slave fields muxed from the owner
  always_comb begin
    in_xfer  = (state_q == XFER);
    in_resp  = (state_q == RESP);
    s_valid  = in_xfer;
    s_addr   = '0;
    s_we     = '0;
    s_wdata  = '0;
    if (in_xfer) begin
      s_addr  = (owner_q == M_DMA) ? m1_addr  : m0_addr;
      s_we    = (owner_q == M_DMA) ? m1_we    : m0_we;
      s_wdata = (owner_q == M_DMA) ? m1_wdata : m0_wdata;
    end
    m0_gnt   = (in_xfer || in_resp) && (owner_q == M_CPU);
    m1_gnt   = (in_xfer || in_resp) && (owner_q == M_DMA);
    m0_done  = in_resp && (owner_q == M_CPU);
    m1_done  = in_resp && (owner_q == M_DMA);
    m0_err   = m0_done && err_q;
    m1_err   = m1_done && err_q;
    m0_rdata = m0_rdata_q;
    m1_rdata = m1_rdata_q;
    owner    = owner_q;
    busy     = (state_q != IDLE);
  end

endmodule
